// File: rtl/zipmmu_refill_if.sv
// Bundle of the refill engine's miss input, PTE read bus, MMU control port,
// status outputs and debug taps; the engine uses 'master', the environment 'slave'.
interface zipmmu_refill_if #(
    parameter int AW    = 30,
    parameter int LGTBL = 6
);
    // Miss request from the MMU
    logic             i_miss;
    logic [AW-1:0]    i_miss_addr;
    logic [AW-1:0]    i_ptbase;

    // PTE read master. Strobe is accepted on a cycle with stb && !stall;
    // ack/err close the read and are only honoured while waiting on it.
    logic             o_wb_cyc;
    logic             o_wb_stb;
    logic             o_wb_we;
    logic [AW-1:0]    o_wb_addr;
    logic             i_wb_stall;
    logic             i_wb_ack;
    logic             i_wb_err;
    logic [31:0]      i_wb_data;

    // MMU control port, same stb/stall acceptance rule as the read bus
    logic             o_mmu_stb;
    logic             o_mmu_we;
    logic [LGTBL+1:0] o_mmu_addr;
    logic [31:0]      o_mmu_data;
    logic             i_mmu_stall;
    logic             i_mmu_ack;

    // Status
    logic             o_busy;
    logic             o_done;
    logic             o_fault;
    logic [AW-1:0]    o_fault_addr;

    // Debug taps
    logic [2:0]       dbg_state;
    logic [LGTBL-1:0] dbg_slot;

    modport master (
        input  i_miss, i_miss_addr, i_ptbase,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        output o_mmu_stb, o_mmu_we, o_mmu_addr, o_mmu_data,
        input  i_mmu_stall, i_mmu_ack,
        output o_busy, o_done, o_fault, o_fault_addr,
        output dbg_state, dbg_slot
    );

    modport slave (
        output i_miss, i_miss_addr, i_ptbase,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        input  o_mmu_stb, o_mmu_we, o_mmu_addr, o_mmu_data,
        output i_mmu_stall, i_mmu_ack,
        input  o_busy, o_done, o_fault, o_fault_addr,
        input  dbg_state, dbg_slot
    );
endinterface

// File: rtl/zipmmu_refill.sv
// TLB refill engine: on an MMU miss it reads the PTE for the faulting page and
// writes the virtual/physical pair into the next round-robin TLB slot.
module zipmmu_refill #(
    parameter int AW      = 30,
    parameter int LGTBL   = 6,
    parameter int LGPGSZB = 12
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    zipmmu_refill_if.master bus
);
    localparam int VPW = AW - (LGPGSZB - 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RDREQ   = 3'd1,
        S_RDWAIT  = 3'd2,
        S_WRV     = 3'd3,
        S_WRP     = 3'd4,
        S_ACKWAIT = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [VPW-1:0]   vpn_q, vpn_d;
    logic [AW-1:0]    miss_addr_q, miss_addr_d;
    logic [AW-1:0]    pte_addr_q, pte_addr_d;
    logic [AW-1:0]    fault_addr_q, fault_addr_d;
    logic [31:0]      pte_q, pte_d;
    logic [LGTBL-1:0] slot_q, slot_d;
    logic [1:0]       ack_cnt_q, ack_cnt_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    logic [VPW-1:0]   miss_vpn;
    logic [31:0]      v_word;
    logic [1:0]       ack_cnt_inc;
    logic             wb_cyc;
    logic             mmu_stb;

    assign miss_vpn = bus.i_miss_addr[AW-1:LGPGSZB-2];
    assign v_word   = 32'(vpn_q) << LGPGSZB;

    // Saturates so a stray extra ack cannot wrap the count back below two
    assign ack_cnt_inc = (bus.i_mmu_ack && (ack_cnt_q != 2'd3)) ? ack_cnt_q + 2'd1 : ack_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            vpn_q        <= '0;
            miss_addr_q  <= '0;
            pte_addr_q   <= '0;
            fault_addr_q <= '0;
            pte_q        <= '0;
            slot_q       <= '0;
            ack_cnt_q    <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            vpn_q        <= vpn_d;
            miss_addr_q  <= miss_addr_d;
            pte_addr_q   <= pte_addr_d;
            fault_addr_q <= fault_addr_d;
            pte_q        <= pte_d;
            slot_q       <= slot_d;
            ack_cnt_q    <= ack_cnt_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vpn_d        = vpn_q;
        miss_addr_d  = miss_addr_q;
        pte_addr_d   = pte_addr_q;
        fault_addr_d = fault_addr_q;
        pte_d        = pte_q;
        slot_d       = slot_q;
        ack_cnt_d    = ack_cnt_q;
        done_d       = 1'b0;
        fault_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ack_cnt_d = 2'd0;
                if (bus.i_miss) begin
                    vpn_d       = miss_vpn;
                    miss_addr_d = bus.i_miss_addr;
                    pte_addr_d  = bus.i_ptbase + AW'(miss_vpn);
                    state_d     = S_RDREQ;
                end
            end
            S_RDREQ: begin
                if (!bus.i_wb_stall) begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                // A bus error outranks an ack arriving in the same cycle
                if (bus.i_wb_err || (bus.i_wb_ack && !bus.i_wb_data[0])) begin
                    fault_d      = 1'b1;
                    fault_addr_d = miss_addr_q;
                    state_d      = S_IDLE;
                end else if (bus.i_wb_ack) begin
                    pte_d     = bus.i_wb_data;
                    ack_cnt_d = 2'd0;
                    state_d   = S_WRV;
                end
            end
            S_WRV: begin
                ack_cnt_d = ack_cnt_inc;
                if (!bus.i_mmu_stall) begin
                    state_d = S_WRP;
                end
            end
            S_WRP: begin
                ack_cnt_d = ack_cnt_inc;
                if (!bus.i_mmu_stall) begin
                    state_d = S_ACKWAIT;
                end
            end
            S_ACKWAIT: begin
                ack_cnt_d = ack_cnt_inc;
                if (ack_cnt_inc >= 2'd2) begin
                    done_d    = 1'b1;
                    slot_d    = slot_q + 1'b1;
                    ack_cnt_d = 2'd0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wb_cyc  = (state_q == S_RDREQ) || (state_q == S_RDWAIT);
    assign mmu_stb = (state_q == S_WRV) || (state_q == S_WRP);

    assign bus.o_wb_cyc  = wb_cyc;
    assign bus.o_wb_stb  = (state_q == S_RDREQ);
    assign bus.o_wb_we   = 1'b0;
    assign bus.o_wb_addr = wb_cyc ? pte_addr_q : '0;

    // Even control-port address holds the virtual tag, odd holds the PTE
    assign bus.o_mmu_stb  = mmu_stb;
    assign bus.o_mmu_we   = mmu_stb;
    assign bus.o_mmu_addr = mmu_stb ? {1'b1, slot_q, (state_q == S_WRP)} : '0;
    assign bus.o_mmu_data = (state_q == S_WRV) ? v_word :
                            (state_q == S_WRP) ? pte_q  : '0;

    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_done       = done_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_fault_addr = fault_addr_q;

    assign bus.dbg_state = state_q;
    assign bus.dbg_slot  = slot_q;
endmodule

// File: tb/tb_zipmmu_refill.sv
// Directed-plus-random bench for zipmmu_refill; expected addresses, tags and
// slots come from page arithmetic on the miss address, not from the RTL.
module tb_zipmmu_refill;
  localparam int AW      = 30;
  localparam int LGTBL   = 6;
  localparam int LGPGSZB = 12;
  localparam int NSLOT   = 1 << LGTBL;
  localparam longint PW  = longint'(1) << (LGPGSZB - 2);

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;

  zipmmu_refill_if #(.AW(AW), .LGTBL(LGTBL)) bus ();

  zipmmu_refill #(.AW(AW), .LGTBL(LGTBL), .LGPGSZB(LGPGSZB)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  // clock
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // reference model state
  int            model_slot = 0;
  logic [AW-1:0] model_fault_addr = '0;
  logic [63:0]   exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc_n++;
    check("stb_exclusive", 64'(bus.o_wb_stb & bus.o_mmu_stb), 64'd0);
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_wb_cyc"},     64'(bus.o_wb_cyc), 64'd0);
    check({pfx, "_wb_stb"},     64'(bus.o_wb_stb), 64'd0);
    check({pfx, "_wb_we"},      64'(bus.o_wb_we), 64'd0);
    check({pfx, "_wb_addr"},    64'(bus.o_wb_addr), 64'd0);
    check({pfx, "_mmu_stb"},    64'(bus.o_mmu_stb), 64'd0);
    check({pfx, "_mmu_we"},     64'(bus.o_mmu_we), 64'd0);
    check({pfx, "_mmu_addr"},   64'(bus.o_mmu_addr), 64'd0);
    check({pfx, "_mmu_data"},   64'(bus.o_mmu_data), 64'd0);
    check({pfx, "_busy"},       64'(bus.o_busy), 64'd0);
    check({pfx, "_done"},       64'(bus.o_done), 64'd0);
    check({pfx, "_fault"},      64'(bus.o_fault), 64'd0);
    check({pfx, "_fault_addr"}, 64'(bus.o_fault_addr), 64'd0);
    check({pfx, "_state"},      64'(bus.dbg_state), 64'd0);
    check({pfx, "_slot"},       64'(bus.dbg_slot), 64'd0);
  endtask

  // kind: 0 = ack, 1 = err, 2 = err and ack together
  task automatic run_refill(input logic [AW-1:0] miss, input logic [AW-1:0] ptb,
                            input logic [31:0] pte, input int kind,
                            input int wstall, input int mstall, input int gap,
                            input bit extra, input bit abort);
    logic [AW-1:0] raddr;
    logic [31:0]   vdata;
    logic [63:0]   exp_w;
    int            t0;
    bit            ok;
    raddr = AW'((longint'(ptb) + longint'(miss) / PW) % (longint'(1) << AW));
    vdata = 32'((longint'(miss) / PW) * (longint'(1) << LGPGSZB));
    ok    = (kind == 0) && pte[0];
    if (ok) begin
      exp_q.push_back({32'(2 * NSLOT + 2 * model_slot), vdata});
      exp_q.push_back({32'(2 * NSLOT + 2 * model_slot + 1), pte});
    end

    bus.i_miss = 1'b1;
    bus.i_miss_addr = miss;
    bus.i_ptbase = ptb;
    t0 = cyc_n;
    tick();
    bus.i_miss = extra;
    bus.i_miss_addr = AW'($urandom);
    bus.i_ptbase = AW'($urandom);
    check("rd_cyc", 64'(bus.o_wb_cyc), 64'd1);
    check("rd_stb", 64'(bus.o_wb_stb), 64'd1);
    check("rd_we", 64'(bus.o_wb_we), 64'd0);
    check("rd_addr", 64'(bus.o_wb_addr), 64'(raddr));
    check("rd_busy", 64'(bus.o_busy), 64'd1);

    bus.i_wb_stall = (wstall > 0);
    for (int i = 0; i < wstall; i++) begin
      tick();
      check("rd_stall_stb", 64'(bus.o_wb_stb), 64'd1);
      check("rd_stall_addr", 64'(bus.o_wb_addr), 64'(raddr));
    end
    bus.i_wb_stall = 1'b0;
    bus.i_miss = 1'b0;
    tick();
    check("rdwait_cyc", 64'(bus.o_wb_cyc), 64'd1);
    check("rdwait_stb", 64'(bus.o_wb_stb), 64'd0);

    bus.i_wb_data = pte;
    bus.i_wb_ack  = (kind != 1);
    bus.i_wb_err  = (kind != 0);
    tick();
    bus.i_wb_ack  = 1'b0;
    bus.i_wb_err  = 1'b0;
    bus.i_wb_data = $urandom;
    check("cyc_drop", 64'(bus.o_wb_cyc), 64'd0);

    if (!ok) begin
      model_fault_addr = miss;
      check("fault_pulse", 64'(bus.o_fault), 64'd1);
      check("fault_addr", 64'(bus.o_fault_addr), 64'(model_fault_addr));
      check("fault_no_done", 64'(bus.o_done), 64'd0);
      check("fault_no_mmu", 64'(bus.o_mmu_stb), 64'd0);
      check("fault_busy", 64'(bus.o_busy), 64'd0);
      tick();
      check("fault_clear", 64'(bus.o_fault), 64'd0);
      check("fault_no_mmu2", 64'(bus.o_mmu_stb), 64'd0);
      check("fault_addr_hold", 64'(bus.o_fault_addr), 64'(model_fault_addr));
      check("fault_slot", 64'(bus.dbg_slot), 64'(model_slot));
      return;
    end

    exp_w = exp_q.pop_front();
    check("wrv_stb", 64'(bus.o_mmu_stb), 64'd1);
    check("wrv_we", 64'(bus.o_mmu_we), 64'd1);
    check("wrv_addr", 64'(bus.o_mmu_addr), 64'(exp_w[63:32]));
    check("wrv_data", 64'(bus.o_mmu_data), 64'(exp_w[31:0]));
    bus.i_mmu_stall = (mstall > 0);
    bus.i_miss = extra;
    bus.i_wb_ack = extra;
    for (int i = 0; i < mstall; i++) begin
      tick();
      check("wrv_stall_stb", 64'(bus.o_mmu_stb), 64'd1);
      check("wrv_stall_addr", 64'(bus.o_mmu_addr), 64'(exp_w[63:32]));
      check("wrv_stall_data", 64'(bus.o_mmu_data), 64'(exp_w[31:0]));
    end
    bus.i_mmu_stall = 1'b0;
    bus.i_miss = 1'b0;
    bus.i_wb_ack = 1'b0;
    tick();

    exp_w = exp_q.pop_front();
    check("wrp_stb", 64'(bus.o_mmu_stb), 64'd1);
    check("wrp_addr", 64'(bus.o_mmu_addr), 64'(exp_w[63:32]));
    check("wrp_data", 64'(bus.o_mmu_data), 64'(exp_w[31:0]));
    bus.i_mmu_ack = 1'b1;
    bus.i_mmu_stall = (mstall > 0);
    for (int i = 0; i < mstall; i++) begin
      tick();
      bus.i_mmu_ack = 1'b0;
      check("wrp_stall_stb", 64'(bus.o_mmu_stb), 64'd1);
      check("wrp_stall_addr", 64'(bus.o_mmu_addr), 64'(exp_w[63:32]));
      check("wrp_stall_data", 64'(bus.o_mmu_data), 64'(exp_w[31:0]));
    end
    bus.i_mmu_stall = 1'b0;
    tick();
    bus.i_mmu_ack = 1'b0;
    check("ackwait_stb", 64'(bus.o_mmu_stb), 64'd0);
    check("ackwait_busy", 64'(bus.o_busy), 64'd1);
    check("ackwait_done", 64'(bus.o_done), 64'd0);

    if (abort) begin
      i_reset_n = 1'b0;
      #1;
      check_quiet("abort");
      model_slot = 0;
      model_fault_addr = '0;
      tick();
      i_reset_n = 1'b1;
      tick();
      check("abort_idle", 64'(bus.o_busy), 64'd0);
      return;
    end

    for (int i = 0; i < gap; i++) begin
      tick();
      check("gap_done", 64'(bus.o_done), 64'd0);
    end
    bus.i_mmu_ack = 1'b1;
    tick();
    bus.i_mmu_ack = 1'b0;
    check("done_pulse", 64'(bus.o_done), 64'd1);
    check("done_busy", 64'(bus.o_busy), 64'd0);
    check("done_fault", 64'(bus.o_fault), 64'd0);
    check("done_fault_addr", 64'(bus.o_fault_addr), 64'(model_fault_addr));
    if (wstall == 0 && mstall == 0 && gap == 0)
      check("latency", 64'(cyc_n - t0), 64'd6);
    model_slot = (model_slot + 1) % NSLOT;
    tick();
    check("done_clear", 64'(bus.o_done), 64'd0);
    check("no_queued_miss", 64'(bus.o_busy), 64'd0);
    check("slot", 64'(bus.dbg_slot), 64'(model_slot));
  endtask

  initial begin
    int succ;
    bit f;
    logic [31:0] pte;
    bus.i_miss = 1'b0;
    bus.i_miss_addr = '0;
    bus.i_ptbase = '0;
    bus.i_wb_stall = 1'b0;
    bus.i_wb_ack = 1'b0;
    bus.i_wb_err = 1'b0;
    bus.i_wb_data = '0;
    bus.i_mmu_stall = 1'b0;
    bus.i_mmu_ack = 1'b0;

    // reset
    repeat (3) @(posedge i_clk);
    #1;
    check_quiet("reset");
    i_reset_n = 1'b1;
    tick();

    // basic refill, then a not-present PTE, then the err/ack race and err alone
    run_refill(30'h0000_2345, 30'h0000_1000, 32'h0040_0001, 0, 0, 0, 0, 0, 0);
    run_refill(30'h0001_2c00, 30'h0000_2000, 32'h0040_0000, 0, 0, 0, 0, 0, 0);
    run_refill(AW'($urandom), AW'($urandom), 32'h0040_0001, 2, 0, 0, 0, 0, 0);
    run_refill(AW'($urandom), AW'($urandom), $urandom | 32'd1, 1, 1, 0, 0, 0, 0);

    // held stalls on both buses, with stray miss and read ack while busy
    run_refill(AW'($urandom), AW'($urandom), $urandom | 32'd1, 0, 3, 2, 1, 1, 0);

    // PTE address wraps modulo 2^AW, and the top page of the address space
    run_refill(30'h3fff_ffff, 30'h3fff_fff0, $urandom | 32'd1, 0, 0, 0, 0, 0, 0);

    // random mix until 65 more successes, which forces a slot wrap
    succ = 0;
    while (succ < 65) begin
      f = ($urandom_range(0, 9) == 0);
      pte = $urandom;
      pte[0] = ($urandom_range(0, 7) != 0);
      if (!f && pte[0]) succ++;
      run_refill(AW'($urandom), AW'($urandom), pte, f ? int'($urandom_range(1, 2)) : 0,
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1),
                 1'($urandom_range(0, 1)), 0);
    end

    // reset while waiting for MMU acks, then a clean refill from slot 0
    run_refill(AW'($urandom), AW'($urandom), $urandom | 32'd1, 0, 0, 0, 0, 0, 1);
    run_refill(30'h0000_2345, 30'h0000_1000, 32'h0040_0001, 0, 0, 0, 0, 0, 0);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zipmmu_refill.md
ZIPMMU_REFILL -- requirements
Module: zipmmu_refill

Interface
REQ-001 The block SHALL have parameter AW, default 30, meaning the CPU word-address width.
REQ-002 The block SHALL have parameter LGTBL, default 6, meaning log2 of the number of TLB slots.
REQ-003 The block SHALL have parameter LGPGSZB, default 12, meaning log2 of the page size in bytes; VPW = AW-(LGPGSZB-2).
REQ-004 The block SHALL have ports i_clk, input, 1, clock; all state on rising edge.
REQ-005 The block SHALL have ports i_reset_n, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have ports i_miss, input, 1, single-cycle TLB-miss strobe from the MMU.
REQ-007 The block SHALL have ports i_miss_addr, input, AW, faulting word address.
REQ-008 The block SHALL have ports i_ptbase, input, AW, page-table base word address.
REQ-009 The block SHALL have ports o_wb_cyc, o_wb_stb, o_wb_we, output, 1 each, read master to memory.
REQ-010 The block SHALL have ports o_wb_addr, output, AW, PTE read address.
REQ-011 The block SHALL have ports i_wb_stall, i_wb_ack, i_wb_err, input, 1 each, memory bus return.
REQ-012 The block SHALL have ports i_wb_data, input, 32, PTE read data.
REQ-013 The block SHALL have ports o_mmu_stb, o_mmu_we, output, 1 each, MMU control-port strobe and write enable.
REQ-014 The block SHALL have ports o_mmu_addr, output, LGTBL+2, MMU control-port address.
REQ-015 The block SHALL have ports o_mmu_data, output, 32, MMU control-port write data.
REQ-016 The block SHALL have ports i_mmu_stall, i_mmu_ack, input, 1 each, MMU control-port return.
REQ-017 The block SHALL have ports o_busy, output, 1, refill in progress.
REQ-018 The block SHALL have ports o_done and o_fault, output, 1 each, one-cycle completion pulses.
REQ-019 The block SHALL have ports o_fault_addr, output, AW, i_miss_addr of the last faulted refill.

Function
REQ-020 The block SHALL implement states IDLE, RDREQ, RDWAIT, WRV, WRP and ACKWAIT.
REQ-021 In IDLE, i_miss SHALL latch VPN = i_miss_addr[AW-1:LGPGSZB-2] and the miss address, and move the FSM to RDREQ.
REQ-022 The PTE address SHALL be i_ptbase + VPN, zero-extended, computed modulo 2^AW.
REQ-023 In RDREQ, o_wb_cyc=o_wb_stb=1 and o_wb_we=0; the FSM SHALL move to RDWAIT on the first cycle with !i_wb_stall.
REQ-024 In RDWAIT, o_wb_cyc=1 and o_wb_stb=0.
- i_wb_err: o_fault pulse, FSM to IDLE; err wins over a same-cycle ack.
- i_wb_ack with PTE bit0=0: o_fault pulse, FSM to IDLE, no MMU write.
- i_wb_ack with PTE bit0=1: latch PTE, FSM to WRV.
REQ-025 o_wb_cyc SHALL deassert the cycle after ack or err; i_wb_ack/err outside RDWAIT SHALL be ignored.
REQ-026 In WRV, the block SHALL drive o_mmu_stb=1, o_mmu_we=1, o_mmu_addr={1'b1,slot,1'b0} and o_mmu_data={VPN zero-padded to 32-LGPGSZB bits, LGPGSZB zeros}; it SHALL move to WRP on !i_mmu_stall.
REQ-027 In WRP, the block SHALL drive o_mmu_addr={1'b1,slot,1'b1} and o_mmu_data=latched PTE; it SHALL move to ACKWAIT on !i_mmu_stall.
REQ-028 A 2-bit ack counter SHALL count i_mmu_ack across WRV/WRP/ACKWAIT; on reaching 2 the block SHALL pulse o_done, advance the slot, and return the FSM to IDLE.
REQ-029 The slot counter SHALL be LGTBL bits wide, round-robin, wrapping 2^LGTBL-1 -> 0, and advance only on o_done.
REQ-030 o_busy SHALL be 1 in every state except IDLE.
REQ-031 i_miss received outside IDLE SHALL be ignored, with no queueing; the MMU re-issues the miss.
REQ-032 o_fault_addr SHALL update only on an o_fault pulse and hold otherwise.
REQ-033 o_mmu_stb and o_wb_stb SHALL never be asserted in the same cycle.
REQ-034 Minimum latency, with no stalls, single-cycle ack, and MMU acks one cycle after each strobe, SHALL be: i_miss at cycle 0 -> o_done at cycle 6.

Reset
REQ-035 Assertion of i_reset_n=0 SHALL, asynchronously, set FSM=IDLE, slot=0, ack count=0, and all strobes/cyc/o_done/o_fault/o_busy=0, o_fault_addr=0.
REQ-036 Reset mid-refill SHALL abandon the transaction with no partial MMU write completed by the block; behaviour SHALL resume on the first rising edge after deassertion.

Verification
REQ-037 Scenario: i_ptbase=0x1000, i_miss_addr=0x0000_2345, PTE=0x0040_0001 -> read addr 0x1008; MMU writes addr 0x80 data 0x0000_8000, addr 0x81 data 0x0040_0001; o_done; slot=1.
REQ-038 Scenario: PTE returned 0x0040_0000 -> o_fault pulse, o_fault_addr=miss address, no o_mmu_stb, slot unchanged.
REQ-039 Scenario: i_wb_err and i_wb_ack asserted together in RDWAIT -> o_fault, o_wb_cyc low next cycle.
REQ-040 Scenario: i_wb_stall held 3 cycles and i_mmu_stall held 2 cycles -> strobes held steady, addresses/data stable, o_done after 2 MMU acks.
REQ-041 Scenario: 65 successful refills -> slots 0..63 then wrap to 0; a second i_miss during busy is ignored.
REQ-042 Scenario: i_reset_n low during ACKWAIT -> all outputs 0 immediately, FSM IDLE, next i_miss starts cleanly.
